csr_bus_master: RTL and testbench

Initiator for the team's CSR memory interface (addr/strb/wdata/rdata/wen/cs), i.e. the host-side counterpart of the per-peripheral CSR slave blocks. Accepts one command at a time on a valid/ready stream, runs exactly one CSR bus cycle, samples read data after a fixed latency, and returns a response on a second valid/ready stream. Sits between a host bridge (debug UART, test access port) and the CSR slaves.

---
 rtl/csr_bus_pkg.sv | 20 ++
 rtl/csr_bus_master.sv | 172 +++++++++++++++++
 tb/tb_csr_bus_master.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/csr_bus_pkg.sv
// Shared types and constants for the CSR bus initiator.
package csr_bus_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 16;
  localparam int DEF_STRB_WIDTH = DEF_DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_WAIT,
    ST_RESP
  } state_t;

  // Why a command was refused without running a bus cycle.
  localparam logic [1:0] ERR_NONE       = 2'd0;
  localparam logic [1:0] ERR_MISALIGNED = 2'd1;
  localparam logic [1:0] ERR_RANGE      = 2'd2;

endpackage

// File: rtl/csr_bus_master.sv
// CSR bus initiator: one command in, exactly one CSR access, one response out.
module csr_bus_master
  import csr_bus_pkg::*;
#(
  parameter int                    DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int                    ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int                    STRB_WIDTH = DEF_STRB_WIDTH,
  parameter int                    READ_LAT   = 0,
  parameter logic [ADDR_WIDTH-1:0] ADDR_LIMIT = 16'h0100
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [STRB_WIDTH-1:0] cmd_strb,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  cs,
  output logic                  wen,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [STRB_WIDTH-1:0] strb,
  output logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  busy
);

  state_t                r_state,     w_state_nxt;
  logic [2:0]            r_cnt,       w_cnt_nxt;
  logic                  r_cmd_ready, w_cmd_ready_nxt;
  logic                  r_rsp_valid, w_rsp_valid_nxt;
  logic [DATA_WIDTH-1:0] r_rsp_rdata, w_rsp_rdata_nxt;
  logic                  r_rsp_err,   w_rsp_err_nxt;
  logic                  r_cs,        w_cs_nxt;
  logic                  r_wen,       w_wen_nxt;
  logic [ADDR_WIDTH-1:0] r_addr,      w_addr_nxt;
  logic [STRB_WIDTH-1:0] r_strb,      w_strb_nxt;
  logic [DATA_WIDTH-1:0] r_wdata,     w_wdata_nxt;
  logic                  r_busy,      w_busy_nxt;

  logic [1:0] w_err_cause;
  logic       w_cmd_err;

  assign w_err_cause = (cmd_addr[1:0] != 2'b00) ? ERR_MISALIGNED :
                       (cmd_addr >= ADDR_LIMIT)  ? ERR_RANGE      : ERR_NONE;
  assign w_cmd_err   = (w_err_cause != ERR_NONE);

  always_comb begin
    // NOTE: every output of this block is given a default before any branch,
    // so no path can leave a value unassigned and infer a latch.
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_cmd_ready_nxt = r_cmd_ready;
    w_rsp_valid_nxt = r_rsp_valid;
    w_rsp_rdata_nxt = r_rsp_rdata;
    w_rsp_err_nxt   = r_rsp_err;
    w_cs_nxt        = r_cs;
    w_wen_nxt       = r_wen;
    w_addr_nxt      = r_addr;
    w_strb_nxt      = r_strb;
    w_wdata_nxt     = r_wdata;
    w_busy_nxt      = r_busy;

    unique case (r_state)
      ST_IDLE: begin
        if (cmd_valid) begin
          w_cmd_ready_nxt = 1'b0;
          w_busy_nxt      = 1'b1;
          if (w_cmd_err) begin
            w_state_nxt     = ST_RESP;
            w_rsp_valid_nxt = 1'b1;
            w_rsp_err_nxt   = 1'b1;
            w_rsp_rdata_nxt = '0;
          end else begin
            w_state_nxt = ST_ACCESS;
            w_cs_nxt    = 1'b1;
            w_wen_nxt   = cmd_write;
            w_addr_nxt  = cmd_addr;
            w_strb_nxt  = cmd_write ? cmd_strb  : '1;
            w_wdata_nxt = cmd_write ? cmd_wdata : '0;
          end
        end
      end

      ST_ACCESS: begin
        w_cs_nxt    = 1'b0;
        w_wen_nxt   = 1'b0;
        w_strb_nxt  = '0;
        w_wdata_nxt = '0;
        if (r_wen || READ_LAT == 0) begin
          w_state_nxt     = ST_RESP;
          w_addr_nxt      = '0;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_rdata_nxt = r_wen ? '0 : rdata;
        end else begin
          // addr stays on the bus so the slave keeps decoding during the wait.
          w_state_nxt = ST_WAIT;
          w_cnt_nxt   = 3'(READ_LAT);
        end
      end

      ST_WAIT: begin
        w_cnt_nxt = r_cnt - 3'd1;
        if (r_cnt == 3'd1) begin
          w_state_nxt     = ST_RESP;
          w_addr_nxt      = '0;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_rdata_nxt = rdata;
        end
      end

      ST_RESP: begin
        if (rsp_ready) begin
          w_state_nxt     = ST_IDLE;
          w_rsp_valid_nxt = 1'b0;
          w_rsp_err_nxt   = 1'b0;
          w_rsp_rdata_nxt = '0;
          w_cmd_ready_nxt = 1'b1;
          w_busy_nxt      = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every register
    // sees pre-edge values, independent of statement order.
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_cmd_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_cs        <= 1'b0;
      r_wen       <= 1'b0;
      r_addr      <= '0;
      r_strb      <= '0;
      r_wdata     <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_cmd_ready <= w_cmd_ready_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
      r_cs        <= w_cs_nxt;
      r_wen       <= w_wen_nxt;
      r_addr      <= w_addr_nxt;
      r_strb      <= w_strb_nxt;
      r_wdata     <= w_wdata_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign cs        = r_cs;
  assign wen       = r_wen;
  assign addr      = r_addr;
  assign strb      = r_strb;
  assign wdata     = r_wdata;
  assign busy      = r_busy;

endmodule

// File: tb/tb_csr_bus_master.sv
// Bench for csr_bus_master: two instances (READ_LAT 0 and 3), each with a CSR
// slave model, a transaction-timeline reference model and directed + random stimulus.
module tb_csr_bus_master;

  localparam int DW     = 32;
  localparam int AW     = 16;
  localparam int SW     = 4;
  localparam int N_RAND = 400;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [1:0] done     = 2'b00;

  task automatic check(input int inst, input string name,
                       input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL inst%0d %s: got %h expected %h at %0t", inst, name, act, exp, $time);
    end
  endtask

  // Slave contents after reset; word 2 (byte 0x0008) is pinned for the literal checks.
  function automatic logic [31:0] init_val(input int i);
    return (i == 2) ? 32'h1234_5678 : ((32'h9E37_79B9 * 32'(i + 1)) ^ 32'h5A5A_0000);
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int LAT = (g == 0) ? 0 : 3;

    logic          rst, cmd_valid, cmd_ready, cmd_write, rsp_valid, rsp_ready;
    logic          rsp_err, cs, wen, busy;
    logic [AW-1:0] cmd_addr, addr;
    logic [SW-1:0] cmd_strb, strb;
    logic [DW-1:0] cmd_wdata, rsp_rdata, wdata, rdata;
    logic [31:0]   slave_mem [64];
    logic [31:0]   model_mem [64];
    int            since_cs;

    csr_bus_master #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW),
      .READ_LAT(LAT), .ADDR_LIMIT(16'h0100)
    ) u_dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_strb(cmd_strb), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .cs(cs), .wen(wen), .addr(addr), .strb(strb),
      .wdata(wdata), .rdata(rdata), .busy(busy)
    );

    // Slave: read data only becomes valid LAT cycles after the cs cycle.
    always @(posedge clk) begin
      if (rst) begin
        since_cs <= 15;
        for (int i = 0; i < 64; i++) slave_mem[i] <= init_val(i);
      end else begin
        since_cs <= cs ? 1 : ((since_cs < 15) ? since_cs + 1 : since_cs);
        if (cs && wen)
          for (int b = 0; b < 4; b++)
            if (strb[b]) slave_mem[addr[7:2]][8*b +: 8] <= wdata[8*b +: 8];
      end
    end

    always_comb begin
      rdata = 32'hBAD0_0BAD;
      if (addr < 16'h0100 && (cs ? 0 : since_cs) >= LAT) rdata = slave_mem[addr[7:2]];
    end

    // Reference model: each transaction is a timeline indexed by t, the
    // number of cycles since its command handshake.
    initial begin : model
      bit          armed = 1'b0;
      bit          m_busy = 1'b0;
      bit          m_err, m_wr;
      int          t = 0;
      int          rstart = 0;
      logic [15:0] m_addr;
      logic [3:0]  m_strb;
      logic [31:0] m_wdata, m_exp;
      logic        e_ready, e_busy, e_cs, e_wen, e_rv, e_err;
      logic [15:0] e_addr;
      logic [3:0]  e_strb;
      logic [31:0] e_wdata, e_rd;
      forever begin
        @(negedge clk);
        if (armed) begin
          e_ready = !m_busy;
          e_busy  = m_busy;
          e_cs    = m_busy && !m_err && t == 1;
          e_wen   = e_cs && m_wr;
          e_strb  = e_cs ? (m_wr ? m_strb : 4'hF) : 4'h0;
          e_wdata = (e_cs && m_wr) ? m_wdata : 32'h0;
          e_addr  = (m_busy && !m_err && t < rstart) ? m_addr : 16'h0;
          e_rv    = m_busy && t >= rstart;
          e_err   = e_rv && m_err;
          e_rd    = (e_rv && !m_err && !m_wr) ? m_exp : 32'h0;
          check(g, "cmd_ready", 32'(cmd_ready), 32'(e_ready));
          check(g, "busy",      32'(busy),      32'(e_busy));
          check(g, "cs",        32'(cs),        32'(e_cs));
          check(g, "wen",       32'(wen),       32'(e_wen));
          check(g, "addr",      32'(addr),      32'(e_addr));
          check(g, "strb",      32'(strb),      32'(e_strb));
          check(g, "wdata",     wdata,          e_wdata);
          check(g, "rsp_valid", 32'(rsp_valid), 32'(e_rv));
          check(g, "rsp_err",   32'(rsp_err),   32'(e_err));
          check(g, "rsp_rdata", rsp_rdata,      e_rd);
        end
        if (rst) begin
          armed  = 1'b1;
          m_busy = 1'b0;
          for (int i = 0; i < 64; i++) model_mem[i] = init_val(i);
        end else if (armed && !m_busy) begin
          if (cmd_valid) begin
            m_wr    = cmd_write;
            m_addr  = cmd_addr;
            m_strb  = cmd_strb;
            m_wdata = cmd_wdata;
            m_err   = (cmd_addr % 4 != 0) || (cmd_addr >= 16'h0100);
            rstart  = m_err ? 1 : (m_wr ? 2 : 2 + LAT);
            m_exp   = 32'h0;
            if (!m_err && !m_wr) m_exp = model_mem[cmd_addr / 4];
            if (!m_err && m_wr)
              for (int b = 0; b < 4; b++)
                if (cmd_strb[b]) model_mem[cmd_addr / 4][8*b +: 8] = cmd_wdata[8*b +: 8];
            m_busy = 1'b1;
            t      = 1;
          end
        end else if (m_busy) begin
          if (t >= rstart && rsp_ready) m_busy = 1'b0;
          else t++;
        end
      end
    end

    // Issues one command with rsp_ready high; reports latency, cs cycles and response.
    task automatic do_cmd(input logic wr, input logic [15:0] a, input logic [3:0] s,
                          input logic [31:0] d, output int lat, output int csn,
                          output logic [31:0] rd, output logic er);
      int guard = 0;
      while (!cmd_ready && guard < 50) begin
        @(posedge clk); #1;
        guard++;
      end
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_strb = s; cmd_wdata = d;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      lat = 1;
      csn = 0;
      while (!rsp_valid && lat < 50) begin
        csn += int'(cs);
        @(posedge clk); #1;
        lat++;
      end
      rd = rsp_rdata;
      er = rsp_err;
      @(posedge clk); #1;
    endtask

    initial begin : stim
      int          lat, csn, guard;
      logic [31:0] rd;
      logic        er;
      rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
      cmd_strb = '0; cmd_wdata = '0; rsp_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      check(g, "reset cmd_ready", 32'(cmd_ready), 32'd1);
      check(g, "reset rsp_valid", 32'(rsp_valid), 32'd0);
      check(g, "reset cs",        32'(cs),        32'd0);

      do_cmd(1'b1, 16'h0004, 4'hF, 32'hDEAD_BEEF, lat, csn, rd, er);
      check(g, "write latency", 32'(lat), 32'd2);
      check(g, "write cs cycles", 32'(csn), 32'd1);
      check(g, "write rsp", {rd[30:0], er}, 32'h0);

      do_cmd(1'b0, 16'h0008, 4'h0, 32'h0, lat, csn, rd, er);
      check(g, "read latency", 32'(lat), 32'(2 + LAT));
      check(g, "read cs cycles", 32'(csn), 32'd1);
      check(g, "read data 0x8", rd, 32'h1234_5678);

      do_cmd(1'b1, 16'h0004, 4'h3, 32'h0000_1111, lat, csn, rd, er);
      do_cmd(1'b0, 16'h0004, 4'h0, 32'h0, lat, csn, rd, er);
      check(g, "partial strobe readback", rd, 32'hDEAD_1111);

      do_cmd(1'b0, 16'h0006, 4'h0, 32'h0, lat, csn, rd, er);
      check(g, "misaligned latency", 32'(lat), 32'd1);
      check(g, "misaligned cs cycles", 32'(csn), 32'd0);
      check(g, "misaligned err", 32'(er), 32'd1);
      do_cmd(1'b1, 16'h0100, 4'hF, 32'hFFFF_FFFF, lat, csn, rd, er);
      check(g, "range latency", 32'(lat), 32'd1);
      check(g, "range err/rdata", {rd[30:0], er}, 32'd1);

      do_cmd(1'b1, 16'h000C, 4'h0, 32'hFFFF_FFFF, lat, csn, rd, er);
      check(g, "zero strobe cs cycles", 32'(csn), 32'd1);
      check(g, "zero strobe err", 32'(er), 32'd0);
      do_cmd(1'b0, 16'h000C, 4'h0, 32'h0, lat, csn, rd, er);
      check(g, "zero strobe readback", rd, init_val(3));

      // Backpressure with a second command already waiting.
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 16'h0008; rsp_ready = 1'b0;
      @(posedge clk); #1;
      guard = 0;
      while (!rsp_valid && guard < 50) begin
        @(posedge clk); #1;
        guard++;
      end
      repeat (5) @(posedge clk);
      #1;
      check(g, "stall rsp_rdata", rsp_rdata, 32'h1234_5678);
      check(g, "stall cmd_ready", 32'(cmd_ready), 32'd0);
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      check(g, "after rsp handshake cmd_ready", 32'(cmd_ready), 32'd1);
      @(posedge clk); #1;
      check(g, "second cmd accepted", 32'(cmd_ready), 32'd0);
      cmd_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1;

      // Reset while the read is in flight.
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 16'h0008; rsp_ready = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check(g, "mid reset cs",        32'(cs),        32'd0);
      check(g, "mid reset rsp_valid", 32'(rsp_valid), 32'd0);
      check(g, "mid reset cmd_ready", 32'(cmd_ready), 32'd1);
      check(g, "mid reset addr",      32'(addr),      32'd0);
      repeat (LAT + 3) @(posedge clk);
      #1;
      check(g, "no stale response", 32'(rsp_valid), 32'd0);
      do_cmd(1'b0, 16'h0008, 4'h0, 32'h0, lat, csn, rd, er);
      check(g, "read after reset", rd, 32'h1234_5678);

      for (int i = 0; i < N_RAND; i++) begin
        cmd_valid = 1'($urandom_range(0, 1));
        rsp_ready = ($urandom_range(0, 3) != 0);
        cmd_write = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 9))
          7:       cmd_addr = 16'($urandom_range(0, 255));
          8, 9:    cmd_addr = 16'($urandom_range(0, 65535));
          default: cmd_addr = 16'($urandom_range(0, 63) * 4);
        endcase
        cmd_strb  = 4'($urandom_range(0, 15));
        cmd_wdata = $urandom;
        @(posedge clk); #1;
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      repeat (15) @(posedge clk);
      #1;
      done[g] = 1'b1;
    end
  end

  initial begin : main
    int cyc = 0;
    while (done != 2'b11 && cyc < 20000) begin
      @(posedge clk);
      cyc++;
    end
    check(0, "bench completion", 32'(done), 32'd3);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
